// File: rtl/mem_dump.sv
// mem_dump: when the CPU is stopped, reads RAM 0x0-0xF over the debug port and streams
// "A:HL" hex lines out an 8N1 UART. Define MEM_DUMP_CRLF_EN for CR LF line endings (else LF).
module mem_dump #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nCLR,
    input  logic       start,
    input  logic       run,
    output logic [3:0] rd_addr,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    output logic       txd,
    output logic       busy,
    output logic       done
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
`ifdef MEM_DUMP_CRLF_EN
    localparam logic [2:0] IdxLast = 3'd5;
`else
    localparam logic [2:0] IdxLast = 3'd4;
`endif

    typedef enum logic [2:0] {StIdle, StRead, StLatch, StSend, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      bit_q, bit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            abort_q, abort_d;
    logic [7:0]      tx_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_ff @(posedge clk or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge nCLR) begin
        if (!nCLR) begin
            addr_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    tx_byte = hex_char(addr_q);
            3'd1:    tx_byte = 8'h3A;
            3'd2:    tx_byte = hex_char(data_q[7:4]);
            3'd3:    tx_byte = hex_char(data_q[3:0]);
`ifdef MEM_DUMP_CRLF_EN
            3'd4:    tx_byte = 8'h0D;
`endif
            default: tx_byte = 8'h0A;
        endcase
    end

    // Abort is sticky so a brief run pulse mid-frame still ends the dump at the stop bit.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        abort_d = abort_q | run;
        case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                if (start && !run) begin
                    state_d = StRead;
                    addr_d  = '0;
                end
            end
            StRead: state_d = abort_d ? StIdle : StLatch;
            StLatch: begin
                if (abort_d) begin
                    state_d = StIdle;
                end else begin
                    data_d  = rd_data;
                    idx_d   = '0;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = '0;
                        if (abort_d) begin
                            state_d = StIdle;
                        end else if (idx_q == IdxLast) begin
                            if (addr_q == 4'hF) begin
                                state_d = StDone;
                            end else begin
                                addr_d  = addr_q + 4'd1;
                                state_d = StRead;
                            end
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_addr = addr_q;
        rd_en   = (state_q == StRead);
        busy    = (state_q == StRead) || (state_q == StLatch) || (state_q == StSend);
        done    = (state_q == StDone);
        txd     = 1'b1;
        if (state_q == StSend) begin
            if (bit_q == 4'd0) begin
                txd = 1'b0;
            end else if (bit_q == 4'd9) begin
                txd = 1'b1;
            end else begin
                txd = tx_byte[3'(bit_q - 4'd1)];
            end
        end
    end

endmodule

// File: tb/tb_mem_dump.sv
// Bench for mem_dump: RAM model, UART decoder feeding a byte scoreboard, scenario tasks.
`timescale 1ns/1ps
module tb_mem_dump;
    localparam int C = 4;
`ifdef MEM_DUMP_CRLF_EN
    localparam int B = 6;
`else
    localparam int B = 5;
`endif
    localparam int L        = B * 10 * C + 2;
    localparam int FullCyc  = 16 * L + 1;
    localparam int RaiseCyc = 3 + 5 * L + 25 * C + C / 2;
    localparam int StopLast = 3 + 5 * L + 30 * C - 1;

    logic       clk = 1'b0;
    logic       nCLR = 1'b0;
    logic       start = 1'b0;
    logic       run = 1'b0;
    logic [3:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       txd, busy, done;

    logic [7:0] ram [16];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         rd_cnt = 0;
    bit         mon_ignore = 1'b0;
    logic [7:0] mon_b, mon_e;
    logic       mon_stop;

    always #5 clk = ~clk;

    mem_dump #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .nCLR    (nCLR),
        .start   (start),
        .run     (run),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .txd     (txd),
        .busy    (busy),
        .done    (done)
    );

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
        if (done) done_cnt <= done_cnt + 1;
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    // UART decoder: samples mid-bit on falling clock edges, checks each byte against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (nCLR === 1'b1 && txd === 1'b0) begin
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    mon_b[i] = txd;
                end
                repeat (C) @(negedge clk);
                mon_stop = txd;
                if (!mon_ignore) begin
                    checks++;
                    if (mon_stop !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit: got %b required 1", mon_stop);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte: got %h required none", mon_b);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_b !== mon_e) begin
                            errors++;
                            $display("FAIL uart_byte: got %h required %h", mon_b, mon_e);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    task automatic push_line(input int a, input int nbytes);
        logic [7:0] line [6];
        line[0] = hexc(a);
        line[1] = 8'h3A;
        line[2] = hexc(int'(ram[a][7:4]));
        line[3] = hexc(int'(ram[a][3:0]));
`ifdef MEM_DUMP_CRLF_EN
        line[4] = 8'h0D;
        line[5] = 8'h0A;
`else
        line[4] = 8'h0A;
        line[5] = 8'h00;
`endif
        for (int i = 0; i < nbytes; i++) exp_q.push_back(line[i]);
    endtask

    task automatic push_dump();
        for (int a = 0; a < 16; a++) push_line(a, B);
    endtask

    // Leaves the bench at cycle 1 (one cycle after start was sampled).
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < 3 * FullCyc) begin
            @(posedge clk); #1 cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd: got %b required 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b required 0", rd_en); end
        checks++; if (rd_addr !== 4'h0) begin errors++; $display("FAIL rst_addr: got %h required 0", rd_addr); end
        repeat (3) @(posedge clk);
        #1 nCLR = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_full_dump();
        int cyc, bd, br;
        for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);
        push_dump();
        bd = done_cnt; br = rd_cnt;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c1_busy: got %b required 1", busy); end
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL c1_rd_en: got %b required 1", rd_en); end
        checks++; if (rd_addr !== 4'h0) begin errors++; $display("FAIL c1_addr: got %h required 0", rd_addr); end
        @(posedge clk); #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL c2_txd: got %b required 1", txd); end
        @(posedge clk); #1;
        checks++; if (txd !== 1'b0) begin errors++; $display("FAIL c3_txd: got %b required 0", txd); end
        wait_done(3, cyc);
        checks++; if (cyc != FullCyc) begin errors++; $display("FAIL full_len: got %0d required %0d", cyc, FullCyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b required 0", busy); end
        repeat (20) @(posedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_left: got %0d required 0", exp_q.size()); end
        checks++; if (done_cnt - bd != 1) begin errors++; $display("FAIL full_done: got %0d required 1", done_cnt - bd); end
        checks++; if (rd_cnt - br != 16) begin errors++; $display("FAIL full_reads: got %0d required 16", rd_cnt - br); end
        exp_q.delete();
    endtask

    task automatic test_hex_boundary();
        int cyc;
        ram[3] = 8'hAB;
        ram[15] = 8'h09;
        push_dump();
        pulse_start();
        wait_done(1, cyc);
        checks++; if (cyc != FullCyc) begin errors++; $display("FAIL hex_len: got %0d required %0d", cyc, FullCyc); end
        repeat (20) @(posedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL hex_left: got %0d required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_run_refuse();
        int bad, br;
        run = 1'b1;
        br = rd_cnt;
        bad = 0;
        pulse_start();
        repeat (60) begin
            if (txd !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL refuse_idle: got %0d bad cycles required 0", bad); end
        checks++; if (rd_cnt != br) begin errors++; $display("FAIL refuse_reads: got %0d required 0", rd_cnt - br); end
        run = 1'b0;
    endtask

    task automatic test_abort();
        int cyc, bd, br;
        for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);
        for (int a = 0; a < 5; a++) push_line(a, B);
        push_line(5, 3);
        bd = done_cnt;
        pulse_start();
        cyc = 1;
        while (cyc < RaiseCyc) begin @(posedge clk); #1 cyc++; end
        run = 1'b1;
        br = rd_cnt;
        while (cyc < StopLast) begin @(posedge clk); #1 cyc++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_stop_busy: got %b required 1", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL abort_txd: got %b required 1", txd); end
        repeat (60) @(posedge clk); #1;
        checks++; if (rd_cnt != br) begin errors++; $display("FAIL abort_reads: got %0d required 0", rd_cnt - br); end
        checks++; if (done_cnt != bd) begin errors++; $display("FAIL abort_done: got %0d required 0", done_cnt - bd); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_left: got %0d required 0", exp_q.size()); end
        exp_q.delete();
        run = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, bd, br;
        push_dump();
        bd = done_cnt; br = rd_cnt;
        pulse_start();
        cyc = 1;
        while (done !== 1'b1 && cyc < 3 * FullCyc) begin
            @(posedge clk); #1 cyc++;
            start = (cyc == 100 || cyc == 1500);
        end
        start = 1'b0;
        checks++; if (cyc != FullCyc) begin errors++; $display("FAIL b2b_len: got %0d required %0d", cyc, FullCyc); end
        repeat (100) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b required 0", busy); end
        checks++; if (done_cnt - bd != 1) begin errors++; $display("FAIL b2b_done: got %0d required 1", done_cnt - bd); end
        checks++; if (rd_cnt - br != 16) begin errors++; $display("FAIL b2b_reads: got %0d required 16", rd_cnt - br); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int cyc, bd;
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1 mon_ignore = 1'b1;
        #5 nCLR = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midrst_txd: got %b required 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
        checks++; if (rd_addr !== 4'h0) begin errors++; $display("FAIL midrst_addr: got %h required 0", rd_addr); end
        repeat (3) @(posedge clk);
        #1 nCLR = 1'b1;
        repeat (60) @(posedge clk);
        mon_ignore = 1'b0;
        push_dump();
        bd = done_cnt;
        pulse_start();
        checks++; if (rd_addr !== 4'h0) begin errors++; $display("FAIL midrst_restart_addr: got %h required 0", rd_addr); end
        wait_done(1, cyc);
        checks++; if (cyc != FullCyc) begin errors++; $display("FAIL midrst_len: got %0d required %0d", cyc, FullCyc); end
        repeat (20) @(posedge clk); #1;
        checks++; if (done_cnt - bd != 1) begin errors++; $display("FAIL midrst_done: got %0d required 1", done_cnt - bd); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_left: got %0d required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        test_reset();
        test_full_dump();
        test_hex_boundary();
        test_run_refuse();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dump.md
# mem_dump

Read-back counterpart to the switch-driven program loader. When the SAP-1 is stopped, this block walks RAM addresses 0x0–0xF, reads each byte over the memory's debug read port, and streams a printable hex listing out a UART TX pin on the Mojo board. It runs on the 50 MHz board clock, not on the CPU's stepped `CLK`, and never drives the CPU buses.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: board-clock cycles per UART bit (50 MHz / 115200).

Ports:
- `clk`  in  1  50 MHz board clock.
- `nCLR`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse, already debounced; requests a dump.
- `run`  in  1  CPU run mode. A dump is refused or aborted while this is high.
- `rd_addr`  out  4  memory debug read address.
- `rd_en`  out  1  one-cycle read strobe.
- `rd_data`  in  8  memory read data, valid the cycle after `rd_en`.
- `txd`  out  1  UART serial output, 8N1, idle high.
- `busy`  out  1  high while a dump is in progress.
- `done`  out  1  one-cycle pulse when a dump completes normally.

## Operation
- Reset values: `txd`=1, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0. The FSM resets to IDLE.
- FSM states:
  - IDLE: `start`=1 and `run`=0 → READ, with address counter = 0. `start` while `run`=1 is ignored.
  - READ: assert `rd_en` for one cycle with `rd_addr` = counter → LATCH.
  - LATCH: capture `rd_data` into the data register; byte index = 0 → SEND.
  - SEND: serialise line byte [index]. At the end of each stop bit, either increment the index or end the line.
  - At end of line: if counter = 15 → DONE; otherwise increment the counter → READ.
  - DONE: pulse `done` for one cycle → IDLE.
- Line format per address, ASCII, uppercase hex:
  - address digit, `:`, data high nibble, data low nibble, then the terminator.
  - Nibble encoding: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
- Bit order on `txd`: start bit (0), data bits 0..7 (LSB first), stop bit (1). Each bit is held exactly `CLKS_PER_BIT` cycles.
- `start` pulses while `busy`=1 are ignored. They are not queued.
- Abort: if `run` goes high while `busy`=1:
  - Any byte already started is finished through its stop bit. `txd` never glitches mid-frame.
  - Then the FSM returns to IDLE with no `done` pulse.
  - If `run` rises in READ or LATCH, the FSM goes directly to IDLE.
- Address counter is 4 bits. It must not wrap past 15 into a second pass.
- Reset mid-frame: `txd` returns to 1 immediately and all state is cleared.

## Timing
- `start` at cycle 0:
  - `busy`=1 and `rd_en`=1 with `rd_addr`=0 at cycle 1.
  - Data latched at cycle 2.
  - `txd` falls (start bit) at cycle 3.
- Bytes within a line are back-to-back: the next start bit begins the cycle after the previous stop bit ends.
- Between lines: READ and LATCH add 2 idle-high cycles before the next start bit.
- `done` and the `busy` fall occur in the same cycle, one cycle after the final stop bit of address 15 ends.
- Full-dump length with CRLF: 16 × 6 × 10 × `CLKS_PER_BIT` + 16 × 2 + 2 cycles. At the default parameter this is about 8.3 ms.

## Configuration
- `MEM_DUMP_CRLF_EN` defined: the line terminator is CR (0x0D) then LF (0x0A), giving 6 bytes per line and 96 bytes per dump.
- Not defined: the terminator is LF only, giving 5 bytes per line and 80 bytes per dump. The byte-index compare and the dump-length formula adjust accordingly.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and a behavioural RAM model with 1-cycle read latency.
- RAM[i]=0x10+i, pulse `start` with `run`=0 → the UART monitor decodes `0:10\r\n` … `F:1F\r\n`. Exactly 96 bytes, one `done` pulse, `busy` low afterwards.
- RAM[3]=0xAB, RAM[0xF]=0x09 → lines `3:AB` and `F:09` appear. Verifies the A–F vs 0–9 boundary and uppercase output.
- Pulse `start` with `run`=1 → `txd` stays 1, `busy` stays 0, no `rd_en`.
- Raise `run` in the middle of data bit 4 of byte 2 on address 5:
  - the frame completes through its stop bit;
  - `busy` falls within 1 cycle of that stop bit ending;
  - no `done` pulse; no further `rd_en`.
- Second `start` pulse while `busy`=1 → output identical to a single dump. No second `done`, no restart.
- Deassert `nCLR` mid start bit → `txd`=1 and `busy`=0 asynchronously. After release, a new `start` produces a clean dump from address 0.
- Build without `MEM_DUMP_CRLF_EN` → 80 bytes total, each line ends with a single 0x0A.
